// File: rtl/game_pkg.sv
// game_pkg: shared game enums, debounce state encoding and default constants.
// Contents:
//   btn_state_t      - debounce FSM states (RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK)
//   game_state_t     - top-level game FSM states
//   game_mode_t      - game mode selection
//   *_DEF constants  - default debounce / long-press cycle counts
//   cnt_width()      - counter width for a modulus, never narrower than one bit
package game_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'b00,
        PRESS_CHK   = 2'b01,
        PRESSED     = 2'b10,
        RELEASE_CHK = 2'b11
    } btn_state_t;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'b00,
        GS_PLAY  = 2'b01,
        GS_PAUSE = 2'b10,
        GS_OVER  = 2'b11
    } game_state_t;

    typedef enum logic {
        GM_SINGLE = 1'b0,
        GM_DUAL   = 1'b1
    } game_mode_t;

    localparam int DEBOUNCE_CYCLES_DEF   = 10000;
    localparam int LONG_PRESS_CYCLES_DEF = 2000000;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debounce_sync2.sv
// sync2: generic two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears both flops to 0
//   d   - asynchronous input
//   q   - synchronized output (second flop)
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            {q, meta} <= 2'b00;
        else
            {q, meta} <= {meta, d};
    end

endmodule

// File: rtl/button_debounce.sv
// button_debounce: turns a raw push-button into one-cycle press/release pulses and a debounced level.
// Parameters:
//   DEBOUNCE_CYCLES   - consecutive stable synchronized samples needed to accept an edge (>= 2)
//   LONG_PRESS_CYCLES - cycles held in PRESSED before long_press fires
// Ports:
//   clk           - system clock
//   rst           - asynchronous active-high reset
//   btn_raw       - raw active-high button, asynchronous to clk
//   press_pulse   - one-cycle pulse per accepted press
//   release_pulse - one-cycle pulse per accepted release
//   btn_level     - debounced button level
//   long_press    - one-cycle pulse on a long hold
// Build option:
//   BUTTON_DEBOUNCE_LONG_PRESS_EN - when defined, builds the long-press detector;
//                                   otherwise long_press is constant 0.
module button_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_pulse,
    output logic release_pulse,
    output logic btn_level,
    output logic long_press
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    btn_state_t    state;
    logic [CW-1:0] cnt;
    logic          btn_sync;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int            LW      = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);

    logic [LW-1:0] lp_cnt;
    logic          long_fired;
`endif

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (btn_sync)
    );

    // cnt only advances in the check states and is cleared on every transition;
    // a check state always exits at CNT_LAST, so the counter cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RELEASED;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            btn_level     <= 1'b0;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
            lp_cnt        <= '0;
            long_fired    <= 1'b0;
            long_press    <= 1'b0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
            long_press    <= 1'b0;
`endif
            case (state)
                RELEASED: begin
                    if (btn_sync) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!btn_sync) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        press_pulse <= 1'b1;
                        btn_level   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_sync) begin
                        state <= RELEASE_CHK;
                        cnt   <= '0;
                    end
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
                    // Saturate at LP_LAST; long_fired keeps the pulse to one per hold.
                    if (lp_cnt != LP_LAST)
                        lp_cnt <= lp_cnt + 1'b1;
                    else if (!long_fired) begin
                        long_press <= 1'b1;
                        long_fired <= 1'b1;
                    end
`endif
                end
                RELEASE_CHK: begin
                    if (btn_sync) begin
                        // Bounce back: the long-press count resumes rather than restarts.
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state         <= RELEASED;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                        btn_level     <= 1'b0;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
                        lp_cnt        <= '0;
                        long_fired    <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifndef BUTTON_DEBOUNCE_LONG_PRESS_EN
    // Always 0; referencing the parameter keeps it meaningful in both builds.
    assign long_press = (LONG_PRESS_CYCLES < 0);
`endif

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed, table-driven check of button_debounce with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
module tb_button_debounce;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic press_pulse;
    logic release_pulse;
    logic btn_level;
    logic long_press;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       r;
        logic       b;
        logic [3:0] e;
        int         n;
        string      name;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    button_debounce #(
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .btn_level     (btn_level),
        .long_press    (long_press)
    );

    function automatic logic [3:0] outs();
        return {press_pulse, release_pulse, btn_level, long_press};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: press/release/level/long got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs, let one rising edge pass, sample on the falling edge.
    task automatic step(input logic r, input logic b, input logic [3:0] exp, input string name);
        rst     = r;
        btn_raw = b;
        @(posedge clk);
        @(negedge clk);
        check(name, outs(), exp);
    endtask

    task automatic steps(input logic r, input logic b, input logic [3:0] exp, input int n, input string name);
        for (int k = 0; k < n; k++)
            step(r, b, exp, name);
    endtask

    task automatic add(input logic r, input logic b, input logic [3:0] e, input int n, input string name);
        vec_t v;
        v.r = r; v.b = b; v.e = e; v.n = n; v.name = name;
        tbl.push_back(v);
    endtask

    // Release from PRESSED with btn_raw low from edge 0: pulse after edge 6.
    task automatic release_seq(input string name);
        steps(0, 0, 4'b0010, 6, {name, "_rel_wait"});
        step(0, 0, 4'b0100, {name, "_rel_pulse"});
        steps(0, 0, 4'b0000, 3, {name, "_released"});
    endtask

    initial begin
        int lp_seen;
        int lp_want;
        logic lp;
        rst     = 1'b1;
        btn_raw = 1'b0;

        add(1, 1, 4'b0000, 1, "rst_tog_hi");
        add(1, 0, 4'b0000, 1, "rst_tog_lo");
        add(1, 1, 4'b0000, 1, "rst_tog_hi");
        add(1, 0, 4'b0000, 1, "rst_tog_lo");
        add(0, 0, 4'b0000, 10, "idle");
        add(0, 1, 4'b0000, 6, "press_wait");
        add(0, 1, 4'b1010, 1, "press_pulse");
        add(0, 1, 4'b0010, 5, "pressed_hold");
        add(0, 0, 4'b0010, 6, "release_wait");
        add(0, 0, 4'b0100, 1, "release_pulse");
        add(0, 0, 4'b0000, 5, "released");
        add(0, 1, 4'b0000, 3, "glitch_hi");
        add(0, 0, 4'b0000, 8, "glitch_after");
        add(0, 1, 4'b0000, 6, "bnc_press_wait");
        add(0, 1, 4'b1010, 1, "bnc_press_pulse");
        add(0, 1, 4'b0010, 3, "bnc_hold");
        add(0, 0, 4'b0010, 2, "bounce_low");
        add(0, 1, 4'b0010, 10, "bounce_back");
        add(0, 0, 4'b0010, 6, "bnc_rel_wait");
        add(0, 0, 4'b0100, 1, "bnc_rel_pulse");
        add(0, 0, 4'b0000, 3, "bnc_released");

        foreach (tbl[i])
            steps(tbl[i].r, tbl[i].b, tbl[i].e, tbl[i].n, tbl[i].name);

        // Reset in PRESS_CHK with the button held: full latency again from the first post-reset edge.
        steps(0, 1, 4'b0000, 4, "mid_chk");
        rst = 1'b1;
        #1;
        check("mid_rst_async", outs(), 4'b0000);
        steps(1, 1, 4'b0000, 2, "mid_rst_hold");
        steps(0, 1, 4'b0000, 6, "post_rst_wait");
        step(0, 1, 4'b1010, "post_rst_press");
        steps(0, 1, 4'b0010, 3, "post_rst_hold");

        // Reset while PRESSED drops the level immediately; a held button re-presses after full latency.
        rst = 1'b1;
        #1;
        check("pressed_rst_async", outs(), 4'b0000);
        step(1, 1, 4'b0000, "pressed_rst_hold");
        steps(0, 1, 4'b0000, 6, "held_rst_wait");
        step(0, 1, 4'b1010, "held_rst_press");
        steps(0, 1, 4'b0010, 2, "held_rst_hold");
        release_seq("held");

        // Long hold: PRESSED entered after edge 6, long_press 20 cycles later (edge 26).
        lp_seen = 0;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        lp_want = 1;
`else
        lp_want = 0;
`endif
        for (int k = 0; k < 40; k++) begin
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
            lp = (k == 26);
`else
            lp = 1'b0;
`endif
            step(0, 1, {logic'(k == 6), 1'b0, logic'(k >= 6), lp}, "long_hold");
            lp_seen += int'(long_press);
        end
        checks++;
        if (lp_seen != lp_want) begin
            errors++;
            $display("FAIL long_count: got %0d long_press pulses expected %0d", lp_seen, lp_want);
        end
        release_seq("long");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Conditions one raw asynchronous push-button input into clean, single-cycle event pulses plus a debounced level.
- Sits directly upstream of the game state FSM. press_pulse drives that FSM's button input, which advances state on every cycle it is high.
- Therefore exactly one pulse per physical press is mandatory.
- Contents: 2-FF synchronizer, 4-state debounce FSM, stability counter.

Parameters:
DEBOUNCE_CYCLES, 10000, consecutive stable synchronized samples required to accept a press or release; legal range >= 2
LONG_PRESS_CYCLES, 2000000, cycles in PRESSED before long_press fires; used only with LONG_PRESS_EN

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
btn_raw  input  1  raw button, asynchronous to clk, active-high
press_pulse  output  1  one-cycle pulse per accepted press
release_pulse  output  1  one-cycle pulse per accepted release
btn_level  output  1  debounced button level
long_press  output  1  one-cycle pulse on long hold; constant 0 without LONG_PRESS_EN

Behaviour:
- Reset (rst=1, async):
  - sync FFs = 0, state = RELEASED, cnt = 0.
  - All outputs 0, long-press counter 0, long_fired = 0.
- Synchronizer: btn_sync = second flop of a 2-FF chain on btn_raw. The FSM sees only btn_sync.
- Counter:
  - cnt width = $clog2(DEBOUNCE_CYCLES).
  - Cleared on every state change.
  - Increments each cycle in PRESS_CHK or RELEASE_CHK; never wraps.
- RELEASED:
  - btn_sync=1 -> PRESS_CHK.
- PRESS_CHK:
  - btn_sync=0 -> RELEASED, no output.
  - Else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED; press_pulse<=1 for exactly that next cycle.
- PRESSED:
  - btn_sync=0 -> RELEASE_CHK.
- RELEASE_CHK:
  - btn_sync=1 -> PRESSED, no new press_pulse.
  - Else if cnt==DEBOUNCE_CYCLES-1 -> RELEASED; release_pulse<=1 for one cycle.
- btn_level = 1 in PRESSED and RELEASE_CHK; registered, updates on the same edge as the pulses.
- Latency: btn_raw rising and held from before edge 0 -> press_pulse high in the cycle after edge DEBOUNCE_CYCLES+2. Release has symmetric latency.
- Glitch rejection: any btn_sync excursion shorter than DEBOUNCE_CYCLES cycles produces no pulse and no level change.
- press_pulse and release_pulse are never high in the same cycle. Consecutive press_pulses are always separated by a release_pulse.
- Reset mid-debounce:
  - All progress is discarded.
  - After rst deasserts, a held button requires the full latency again, measured from the first post-reset edge.
- btn_raw held high through reset: press_pulse is still generated after the full latency. No suppression.

Optional Feature:
Macro: BUTTON_DEBOUNCE_LONG_PRESS_EN
- Defined:
  - A long-press counter (width $clog2(LONG_PRESS_CYCLES)) counts cycles while state==PRESSED. It holds its value during RELEASE_CHK and clears on entry to RELEASED.
  - When it reaches LONG_PRESS_CYCLES-1, long_press pulses for one cycle and long_fired is set.
  - long_fired blocks re-firing until RELEASED is entered.
  - A bounce returning RELEASE_CHK -> PRESSED continues the count; it does not restart it.
- Undefined:
  - No counter or long_fired logic is built.
  - long_press is tied to 0.

Decomposition:
- Shared package game_pkg:
  - BTN_STATE enum (RELEASED=2'b00, PRESS_CHK=2'b01, PRESSED=2'b10, RELEASE_CHK=2'b11).
  - Default debounce constants, alongside the existing GAME_STATE/GAME_MODE enums.
- Sub-module: sync2 (generic 2-FF synchronizer, async active-high reset to 0), reused for other external inputs.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
- Reset check: rst=1 with btn_raw toggling -> all outputs 0. Deassert rst with btn_raw=0 for 10 cycles -> outputs stay 0.
- Clean press: btn_raw 0->1 before edge 0 and held -> press_pulse high only in the cycle after edge 6; btn_level=1 from then. Drop btn_raw and hold -> release_pulse after the same latency; btn_level=0.
- Glitch: btn_raw high for 3 cycles, then low -> no pulse, btn_level stays 0.
- Release bounce: in PRESSED, btn_raw low for 2 cycles then high -> no release_pulse, no second press_pulse, btn_level stays 1.
- Mid-operation reset: assert rst during PRESS_CHK with btn_raw held high -> outputs 0. After deassert, press_pulse appears in the cycle after post-reset edge 6.
- Long press: hold 40 cycles with BUTTON_DEBOUNCE_LONG_PRESS_EN defined -> exactly one long_press, 20 cycles after entering PRESSED. Build without the macro -> long_press stays 0.
